muldiv_stall_ctrl: RTL

Parametrised multi-cycle execute stall controller for the pipelined CPU. It sits beside the EX stage and decodes the ALU control word for multiply and divide operations. It freezes the front of the pipeline for a per-class configurable latency, then presents a one-cycle result-valid window. It replaces the fixed-latency divide-only staller and adds multiply support, flush, early completion from the arithmetic unit, and back-pressure from the downstream stage.

---
 rtl/muldiv_stall_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/muldiv_stall_ctrl.sv
// Multi-cycle execute stall controller for multiply/divide in EX.
// Freezes the front end for a per-class latency, then opens a one-cycle result window.
module muldiv_stall_ctrl #(
  parameter int DIV_LAT = 8,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       alu_ctrl,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic             unit_done,
  input  logic             hold_down,
  output logic             stall,
  output logic             start_mul,
  output logic             start_div,
  output logic             result_valid,
  output logic [1:0]       busy_kind,
  output logic [CNT_W-1:0] cycles_left
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {K_NONE = 2'b00, K_MUL = 2'b01, K_DIV = 2'b10} kind_t;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_n;
  kind_t            kind_q, kind_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic is_div, is_mul, is_md, lat_is_one;

  assign is_div     = alu_ctrl[4] & alu_ctrl[2];
  assign is_mul     = alu_ctrl[4] & ~alu_ctrl[2];
  assign is_md      = ex_valid & (is_div | is_mul);
  assign lat_is_one = is_div ? (DIV_LAT == 1) : (MUL_LAT == 1);

  assign cycles_left = cnt_q;

  // NOTE: non-blocking assignments so every state register samples the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      kind_q  <= K_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      kind_q  <= kind_n;
      cnt_q   <= cnt_n;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path infers a latch.
  always_comb begin
    state_n      = state_q;
    kind_n       = kind_q;
    cnt_n        = cnt_q;
    stall        = 1'b0;
    start_mul    = 1'b0;
    start_div    = 1'b0;
    result_valid = 1'b0;
    busy_kind    = kind_q;

    if (flush) begin
      state_n = S_IDLE;
      kind_n  = K_NONE;
      cnt_n   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Reset is folded into the trigger so outputs read zero while it is held.
          if (is_md && !reset) begin
            stall     = 1'b1;
            start_div = is_div;
            start_mul = is_mul;
            kind_n    = is_div ? K_DIV : K_MUL;
            busy_kind = kind_n;
            if (lat_is_one) begin
              state_n = S_DONE;
              cnt_n   = '0;
            end else begin
              state_n = S_RUN;
              cnt_n   = is_div ? DIV_LOAD : MUL_LOAD;
            end
          end
        end
        S_RUN: begin
          stall = 1'b1;
          if (cnt_q == CNT_ONE || unit_done) begin
            state_n = S_DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          // Retiring instruction is the mul/div itself, so no re-trigger from here.
          result_valid = 1'b1;
          stall        = hold_down;
          cnt_n        = '0;
          if (!hold_down) begin
            state_n = S_IDLE;
            kind_n  = K_NONE;
          end
        end
        default: begin
          state_n = S_IDLE;
          kind_n  = K_NONE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule
